// File: rtl/input_conditioner_if.sv
// ---------------------------------------------------------------------------
// input_conditioner_if
// Player-side bus of the input conditioner.
//   en             : movement/attack enabled (game is in the fight state)
//   busy           : player cannot accept an attack this cycle
//   left, right    : conditioned movement levels, active-high
//   attack         : one-cycle attack command pulse
//   attack_pending : a buffered attack is waiting
//   attack_expired : one-cycle pulse when a buffered attack is discarded
// Modports:
//   master : the conditioner (drives the movement/attack outputs)
//   slave  : the player/game logic (drives en and busy)
// ---------------------------------------------------------------------------
interface input_conditioner_if;
  logic en;
  logic busy;
  logic left;
  logic right;
  logic attack;
  logic attack_pending;
  logic attack_expired;

  modport master (
    input  en,
    input  busy,
    output left,
    output right,
    output attack,
    output attack_pending,
    output attack_expired
  );

  modport slave (
    output en,
    output busy,
    input  left,
    input  right,
    input  attack,
    input  attack_pending,
    input  attack_expired
  );
endinterface

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
// Synchronizes, debounces and conditions three active-low raw buttons
// (left, right, attack) into movement levels and a one-shot attack command,
// with optional buffering of an attack pressed while the player is busy.
//
// Parameters:
//   DB_CNT  : consecutive differing cycles before a debounced value flips (1..15)
//   BUF_CNT : lifetime of a buffered attack in cycles (1..63)
//
// Ports:
//   clk          : clock, all state updates on the rising edge
//   rst_n        : synchronous active-low reset
//   raw_left_n   : raw left button, active-low, asynchronous
//   raw_right_n  : raw right button, active-low, asynchronous
//   raw_attack_n : raw attack button, active-low, asynchronous
//   bus          : input_conditioner_if.master (en, busy, left, right,
//                  attack, attack_pending, attack_expired)
//
// Configuration:
//   INPUT_ATTACK_BUFFER_EN defined   : an attack pressed while busy is held
//                                      for up to BUF_CNT cycles.
//   INPUT_ATTACK_BUFFER_EN undefined : an attack pressed while busy is
//                                      dropped; pending/expired stay 0.
// ---------------------------------------------------------------------------
module input_conditioner #(
  parameter int unsigned DB_CNT  = 2,
  parameter int unsigned BUF_CNT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  raw_left_n,
  input  logic                  raw_right_n,
  input  logic                  raw_attack_n,
  input_conditioner_if.master   bus
);

  localparam logic [3:0] DB_LIM = 4'(DB_CNT);

  // Channel index: 0 = left, 1 = right, 2 = attack.
  logic [2:0]      sync1_q, sync1_d;
  logic [2:0]      sync2_q, sync2_d;
  logic [2:0]      db_q, db_d;
  logic [2:0][3:0] cnt_q, cnt_d;
  logic            att_dly_q, att_dly_d;
  logic            attack_q, attack_d;
  logic            att_event_s;

  // Synchronizer and debounce next-state. Inversion happens before the
  // first flop so that reset (all zeros) means "released".
  always_comb begin
    sync1_d = ~{raw_attack_n, raw_right_n, raw_left_n};
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if ((cnt_q[i] + 4'd1) == DB_LIM) begin
          db_d[i]  = ~db_q[i];
          cnt_d[i] = 4'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end else begin
        cnt_d[i] = 4'd0;
      end
    end
  end

  // Rising edge of the debounced attack: one event per press.
  assign att_dly_d   = db_q[2];
  assign att_event_s = db_q[2] & ~att_dly_q;

`ifdef INPUT_ATTACK_BUFFER_EN
  localparam logic [5:0] BUF_INIT = 6'(BUF_CNT - 1);

  logic       pending_q, pending_d;
  logic       expired_q, expired_d;
  logic [5:0] timer_q, timer_d;

  // Attack arbitration with buffering; branch order is the priority.
  always_comb begin
    attack_d  = 1'b0;
    expired_d = 1'b0;
    pending_d = pending_q;
    timer_d   = timer_q;
    if (!bus.en) begin
      pending_d = 1'b0;
      timer_d   = 6'd0;
    end else if ((att_event_s | pending_q) & ~bus.busy) begin
      attack_d  = 1'b1;
      pending_d = 1'b0;
    end else if (att_event_s & bus.busy) begin
      // A fresh press while already pending restarts the lifetime.
      pending_d = 1'b1;
      timer_d   = BUF_INIT;
    end else if (pending_q & bus.busy & (timer_q == 6'd0)) begin
      pending_d = 1'b0;
      expired_d = 1'b1;
    end else if (pending_q & bus.busy) begin
      timer_d = timer_q - 6'd1;
    end else begin
      pending_d = pending_q;
      timer_d   = timer_q;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      expired_q <= 1'b0;
      timer_q   <= 6'd0;
    end else begin
      pending_q <= pending_d;
      expired_q <= expired_d;
      timer_q   <= timer_d;
    end
  end

  assign bus.attack_pending = pending_q;
  assign bus.attack_expired = expired_q;
`else
  // Attack fires only when the player can take it at the press instant.
  always_comb begin
    attack_d = 1'b0;
    if (bus.en & att_event_s & ~bus.busy) begin
      attack_d = 1'b1;
    end else begin
      attack_d = 1'b0;
    end
  end

  assign bus.attack_pending = 1'b0;
  assign bus.attack_expired = 1'b0;
`endif

  // Synchronizer, debounce and attack pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 3'd0;
      sync2_q   <= 3'd0;
      db_q      <= 3'd0;
      cnt_q     <= 12'd0;
      att_dly_q <= 1'b0;
      attack_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      att_dly_q <= att_dly_d;
      attack_q  <= attack_d;
    end
  end

  // Opposing directions cancel each other.
  assign bus.left   = bus.en & db_q[0] & ~db_q[1];
  assign bus.right  = bus.en & db_q[1] & ~db_q[0];
  assign bus.attack = attack_q;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

`ifdef INPUT_ATTACK_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic raw_left_n;
  logic raw_right_n;
  logic raw_attack_n;
  int   errors = 0;
  int   checks = 0;

  input_conditioner_if bus_if ();

  input_conditioner #(.DB_CNT(2), .BUF_CNT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw_left_n   (raw_left_n),
    .raw_right_n  (raw_right_n),
    .raw_attack_n (raw_attack_n),
    .bus          (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One rising edge has passed when this returns (we sit on the falling edge).
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    raw_left_n   = 1'b1;
    raw_right_n  = 1'b1;
    raw_attack_n = 1'b1;
    bus_if.en    = 1'b0;
    bus_if.busy  = 1'b0;
    tick();
    tick();
    chk("rst_left",    bus_if.left,           1'b0);
    chk("rst_right",   bus_if.right,          1'b0);
    chk("rst_attack",  bus_if.attack,         1'b0);
    chk("rst_pending", bus_if.attack_pending, 1'b0);
    chk("rst_expired", bus_if.attack_expired, 1'b0);
    rst_n     = 1'b1;
    bus_if.en = 1'b1;
    tick();
    tick();

    // Left press: visible after edge 3, release likewise.
    raw_left_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("left_on%0d", i), bus_if.left, (i == 3) ? 1'b1 : 1'b0);
      chk($sformatf("right_off%0d", i), bus_if.right, 1'b0);
    end
    raw_left_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("left_rel%0d", i), bus_if.left, (i == 3) ? 1'b0 : 1'b1);
    end

    // One-cycle glitch on attack never reaches the debounced value.
    raw_attack_n = 1'b0;
    tick();
    raw_attack_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("glitch%0d", i), bus_if.attack, 1'b0);
    end

    // Held attack with busy=0: single pulse after edge 4.
    raw_attack_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("hold%0d", i), bus_if.attack, (i == 4) ? 1'b1 : 1'b0);
    end
    raw_attack_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold_rel%0d", i), bus_if.attack, 1'b0);
    end

    // Both directions cancel; right alone works; en=0 masks it.
    raw_left_n  = 1'b0;
    raw_right_n = 1'b0;
    repeat (4) tick();
    chk("both_left",  bus_if.left,  1'b0);
    chk("both_right", bus_if.right, 1'b0);
    raw_left_n = 1'b1;
    repeat (4) tick();
    chk("only_right", bus_if.right, 1'b1);
    chk("only_left",  bus_if.left,  1'b0);
    bus_if.en = 1'b0;
    #1;
    chk("en0_right", bus_if.right, 1'b0);
    raw_right_n = 1'b1;
    tick();
    bus_if.en = 1'b1;
    repeat (4) tick();
    chk("right_rel", bus_if.right, 1'b0);

    // Press while busy, busy drops after 5 pending cycles.
    bus_if.busy  = 1'b1;
    raw_attack_n = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      chk($sformatf("buf_pend%0d", i), bus_if.attack_pending,
          (BUF_EN && i >= 4 && i <= 8) ? 1'b1 : 1'b0);
      chk($sformatf("buf_att%0d", i), bus_if.attack,
          (BUF_EN && i == 9) ? 1'b1 : 1'b0);
      chk($sformatf("buf_exp%0d", i), bus_if.attack_expired, 1'b0);
      if (i == 8) bus_if.busy = 1'b0;
    end
    raw_attack_n = 1'b1;
    repeat (5) tick();

    // Press while busy for a long stretch: buffered attack expires.
    bus_if.busy  = 1'b1;
    raw_attack_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("exp_pend%0d", i), bus_if.attack_pending,
          (BUF_EN && i >= 4 && i <= 11) ? 1'b1 : 1'b0);
      chk($sformatf("exp_pulse%0d", i), bus_if.attack_expired,
          (BUF_EN && i == 12) ? 1'b1 : 1'b0);
      chk($sformatf("exp_att%0d", i), bus_if.attack, 1'b0);
    end
    bus_if.busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("exp_after%0d", i), bus_if.attack, 1'b0);
    end
    raw_attack_n = 1'b1;
    repeat (5) tick();

    // en=0 while pending clears it with no attack and no expiry.
    bus_if.busy  = 1'b1;
    raw_attack_n = 1'b0;
    repeat (6) tick();
    chk("en_pend_set", bus_if.attack_pending, BUF_EN);
    bus_if.en = 1'b0;
    tick();
    chk("en_pend_clr", bus_if.attack_pending, 1'b0);
    chk("en_no_att",   bus_if.attack,         1'b0);
    chk("en_no_exp",   bus_if.attack_expired, 1'b0);
    bus_if.busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) bus_if.en = 1'b1;
      chk($sformatf("en_quiet%0d", i), bus_if.attack, 1'b0);
      chk($sformatf("en_quiet_exp%0d", i), bus_if.attack_expired, 1'b0);
    end
    raw_attack_n = 1'b1;
    repeat (5) tick();

    // Reset while pending and attack held: pending dropped, fresh press later.
    bus_if.busy  = 1'b1;
    raw_attack_n = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_pend", bus_if.attack_pending, 1'b0);
    chk("rst_mid_exp",  bus_if.attack_expired, 1'b0);
    chk("rst_mid_att",  bus_if.attack,         1'b0);
    tick();
    bus_if.busy = 1'b0;
    rst_n       = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rst_fresh%0d", i), bus_if.attack, (i == 4) ? 1'b1 : 1'b0);
      chk($sformatf("rst_fresh_exp%0d", i), bus_if.attack_expired, 1'b0);
    end
    raw_attack_n = 1'b1;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DB_CNT, default 2, SHALL set the consecutive-cycle count a synchronized input must differ from its debounced value before the debounced value flips (range 1..15).
REQ-002 Parameter BUF_CNT, default 8, SHALL set the attack buffer lifetime in cycles (range 1..63).
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst_n, input, 1: reset; synchronous and active-low.
REQ-005 Port raw_left_n, input, 1: raw left button, active-low, asynchronous to clk.
REQ-006 Port raw_right_n, input, 1: raw right button, active-low, asynchronous to clk.
REQ-007 Port raw_attack_n, input, 1: raw attack button, active-low, asynchronous to clk.
REQ-008 Port en, input, 1: movement/attack outputs enabled (game in fight state).
REQ-009 Port busy, input, 1: the player cannot accept an attack this cycle.
REQ-010 Port left, output, 1: conditioned left level, active-high.
REQ-011 Port right, output, 1: conditioned right level, active-high.
REQ-012 Port attack, output, 1: one-cycle attack command pulse.
REQ-013 Port attack_pending, output, 1: a buffered attack is waiting.
REQ-014 Port attack_expired, output, 1: one-cycle pulse when a buffered attack is discarded.

Function
REQ-015 Each raw input SHALL pass through a two-flop synchronizer and be inverted to active-high; no other logic SHALL read raw inputs.
REQ-016 Debounce: per channel, a counter SHALL increment each cycle the synchronized value differs from the debounced value, reset to 0 on any cycle they match, and on reaching DB_CNT flip the debounced value and clear to 0.
REQ-017 A raw level held stable from before edge 0 SHALL appear on the debounced value after edge 1+DB_CNT; a glitch shorter than DB_CNT synchronized cycles SHALL never reach the debounced value.
REQ-018 left = en & dbL & ~dbR and right = en & dbR & ~dbL (combinational from debounced registers); both pressed SHALL yield both 0.
REQ-019 Press event SHALL be the cycle where debounced attack = 1 and its one-cycle-delayed copy = 0; a held button SHALL produce exactly one event.
REQ-020 Registered attack logic, evaluated per edge in priority order:
  a) en = 0: attack<=0, pending<=0, timer<=0, no expired pulse.
  b) (event | pending) & ~busy: attack<=1, pending<=0.
  c) event & busy: pending<=1, timer<=BUF_CNT-1 (a new press while pending restarts the timer).
  d) pending & busy & timer = 0: pending<=0, attack_expired<=1.
  e) pending & busy & timer > 0: timer<=timer-1.
  attack and attack_expired SHALL be 0 in every cycle not set by b) or d).
REQ-021 Latency: event with busy = 0 SHALL assert attack in the cycle after the event cycle; a buffered attack SHALL fire the cycle after busy first samples 0, at most BUF_CNT busy cycles after buffering.
REQ-022 attack_pending SHALL equal the pending register; attack and attack_pending SHALL never both be 1.
REQ-023 Timer width SHALL be 6 bits; no wrap below 0.

Reset
REQ-024 With rst_n = 0 at an edge, synchronizer flops, debounced values, delayed copy, counters, pending, timer, attack, attack_expired SHALL all become 0; left/right SHALL therefore read 0.
REQ-025 Reset mid-operation SHALL discard any pending attack with no expired pulse; a button held across reset SHALL produce one fresh press event after 2+DB_CNT cycles.

Configuration
REQ-026 Macro INPUT_ATTACK_BUFFER_EN defined: REQ-020 c)-e) buffering as specified.
REQ-027 Macro undefined: an event with busy = 1 SHALL be dropped; pending, timer, attack_pending, attack_expired SHALL be constant 0; REQ-020 b) reduces to event & ~busy.

Verification (DB_CNT=2, BUF_CNT=8, macro defined unless stated)
REQ-028 raw_left_n driven 0 before edge 0, en=1 -> left=1 after edge 3, right stays 0; release -> left=0 after release edge+3.
REQ-029 raw_attack_n low for 1 synchronized cycle only -> no attack; held low 20 cycles, busy=0 -> exactly one attack pulse, 1 cycle wide.
REQ-030 Press with busy=1, busy drops after 5 cycles -> attack_pending=1 for 5 cycles, attack pulse the cycle after busy=0 sampled, pending=0.
REQ-031 Press with busy=1 held 12 cycles -> attack_expired pulse 8 cycles after buffering, pending=0, no attack.
REQ-032 Both left and right held -> left=right=0; en=0 with pending=1 -> pending cleared, no attack, no expired.
REQ-033 Macro undefined, press with busy=1 then busy=0 -> no attack, attack_pending constant 0; rst_n=0 while attack held -> one attack pulse 4 cycles after rst_n returns high.
